bcd2_scan7: RTL and testbench

Time-multiplexed 7-segment driver for the two-digit BCD counter output. It consumes the 8-bit packed BCD value {tens, ones} and drives one shared 7-segment bus plus two digit enables, alternating digits at a fixed scan rate. It sits directly downstream of the 2-digit counter, between it and the board display pins. Includes an input snapshot register, leading-zero blanking, invalid-code indication and a blank control.

---
 rtl/bcd2_scan7_pkg.sv | 28 ++
 rtl/bcd2_scan7_seg7_dec.sv | 26 ++
 rtl/bcd2_scan7.sv | 69 ++++++
 tb/tb_bcd2_scan7.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/bcd2_scan7_pkg.sv
// Shared constants for the 2-digit BCD 7-segment scan driver: digit patterns,
// special segment codes, digit indices and the prescaler width helper.
package bcd2_scan7_pkg;

    // Segment order {a,b,c,d,e,f,g}, bit6 = a, active-high.
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h01;

    typedef enum logic {
        DIG_ONES = 1'b0,
        DIG_TENS = 1'b1
    } dig_t;

    function automatic int unsigned cnt_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/bcd2_scan7_seg7_dec.sv
// Nibble to 7-segment decoder, active-high; non-BCD codes show a dash.
module seg7_dec
    import bcd2_scan7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (nib)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd2_scan7.sv
// Two-digit time-multiplexed 7-segment driver with input snapshot,
// leading-zero blanking, blank control and selectable pin polarity.
module bcd2_scan7
    import bcd2_scan7_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000,
    parameter bit          BLANK_LZ = 1'b1,
    parameter bit          ACT_LOW  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] bcd_in,
    input  logic       blank,
    output logic [6:0] seg_out,
    output logic [1:0] dig_en
);

    localparam int unsigned     CW   = cnt_width(SCAN_DIV);
    localparam logic [CW-1:0]   LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] div_cnt;
    dig_t          cur;
    logic [7:0]    snap;
    logic          tick;
    logic [3:0]    nib;
    logic [6:0]    dec;
    logic [6:0]    seg_hi;
    logic [1:0]    dig_hi;

    assign tick = (div_cnt == LAST);

    // bcd_in is captured only at slot boundaries so a slot never changes mid-way.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            cur     <= DIG_ONES;
            snap    <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            cur     <= (cur == DIG_ONES) ? DIG_TENS : DIG_ONES;
            snap    <= bcd_in;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    assign nib = (cur == DIG_TENS) ? snap[7:4] : snap[3:0];

    seg7_dec u_dec (
        .nib (nib),
        .seg (dec)
    );

    always_comb begin
        seg_hi = dec;
        dig_hi = (cur == DIG_TENS) ? 2'b10 : 2'b01;
        if (BLANK_LZ && (cur == DIG_TENS) && (snap[7:4] == 4'd0)) begin
            seg_hi = SEG_BLANK;
        end
        if (blank) begin
            seg_hi = SEG_BLANK;
            dig_hi = '0;
        end
    end

    assign seg_out = ACT_LOW ? ~seg_hi : seg_hi;
    assign dig_en  = ACT_LOW ? ~dig_hi : dig_hi;

endmodule

// File: tb/tb_bcd2_scan7.sv
// Scoreboard bench for bcd2_scan7: four parameterisations share one stimulus
// stream; expected outputs come from a cycle-count model of the scan timing.
module tb_bcd2_scan7;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] bcd_in;
    logic       blank;

    logic [6:0] seg_m, seg_n, seg_a, seg_f;
    logic [1:0] dig_m, dig_n, dig_a, dig_f;

    always #5 clk = ~clk;

    bcd2_scan7 #(.SCAN_DIV(4), .BLANK_LZ(1'b1), .ACT_LOW(1'b0)) u_main (
        .clk(clk), .reset(reset), .bcd_in(bcd_in), .blank(blank),
        .seg_out(seg_m), .dig_en(dig_m));

    bcd2_scan7 #(.SCAN_DIV(4), .BLANK_LZ(1'b0), .ACT_LOW(1'b0)) u_nolz (
        .clk(clk), .reset(reset), .bcd_in(bcd_in), .blank(blank),
        .seg_out(seg_n), .dig_en(dig_n));

    bcd2_scan7 #(.SCAN_DIV(4), .BLANK_LZ(1'b1), .ACT_LOW(1'b1)) u_actlow (
        .clk(clk), .reset(reset), .bcd_in(bcd_in), .blank(blank),
        .seg_out(seg_a), .dig_en(dig_a));

    bcd2_scan7 #(.SCAN_DIV(1), .BLANK_LZ(1'b1), .ACT_LOW(1'b0)) u_fast (
        .clk(clk), .reset(reset), .bcd_in(bcd_in), .blank(blank),
        .seg_out(seg_f), .dig_en(dig_f));

    typedef struct packed {
        logic [8:0] m;
        logic [8:0] n;
        logic [8:0] a;
        logic [8:0] f;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: cycles since reset and the value latched at the last slot boundary.
    int         cyc4, cyc1;
    logic [7:0] snap4, snap1;
    bit         valid = 0;

    logic [6:0] pat [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                             7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    function automatic logic [8:0] expect_out(input logic [7:0] s, input bit tens,
                                              input logic bl, input bit blz, input bit al);
        logic [3:0] d;
        logic [6:0] sg;
        logic [1:0] dg;
        d  = tens ? s[7:4] : s[3:0];
        sg = (d <= 4'd9) ? pat[d] : 7'h01;
        if (tens && blz && s[7:4] == 4'd0) sg = 7'h00;
        dg = tens ? 2'b10 : 2'b01;
        if (bl) begin
            sg = 7'h00;
            dg = 2'b00;
        end
        if (al) begin
            sg = ~sg;
            dg = ~dg;
        end
        return {sg, dg};
    endfunction

    task automatic step(input logic r, input logic [7:0] b, input logic bl);
        exp_t e;
        bit   t4, t1;
        @(posedge clk);
        if (reset) begin
            cyc4 = 0; cyc1 = 0; snap4 = 8'h00; snap1 = 8'h00; valid = 1;
        end else if (valid) begin
            cyc4++;
            if (cyc4 % 4 == 0) snap4 = bcd_in;
            cyc1++;
            snap1 = bcd_in;
        end
        #1;
        reset  = r;
        bcd_in = b;
        blank  = bl;
        if (valid) begin
            t4  = ((cyc4 / 4) % 2) == 1;
            t1  = (cyc1 % 2) == 1;
            e.m = expect_out(snap4, t4, bl, 1, 0);
            e.n = expect_out(snap4, t4, bl, 0, 0);
            e.a = expect_out(snap4, t4, bl, 1, 1);
            e.f = expect_out(snap1, t1, bl, 1, 0);
            sb.push_back(e);
        end
    endtask

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @%0t: got seg=%h dig=%b, expected seg=%h dig=%b",
                     name, $time, got[8:2], got[1:0], want[8:2], want[1:0]);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("main",   {seg_m, dig_m}, e.m);
            check("no_lz",  {seg_n, dig_n}, e.n);
            check("actlow", {seg_a, dig_a}, e.a);
            check("div1",   {seg_f, dig_f}, e.f);
        end
    end

    initial begin
        int guard;
        reset  = 1'b1;
        bcd_in = 8'h37;
        blank  = 1'b0;

        // reset, then count with 37
        step(1, 8'h37, 0);
        step(0, 8'h37, 0);
        repeat (20) step(0, 8'h37, 0);

        // leading zero
        step(1, 8'h05, 0);
        repeat (16) step(0, 8'h05, 0);

        // mid-slot change: 11 held into slot 1, then 99 at its second cycle
        step(1, 8'h11, 0);
        repeat (4) step(0, 8'h11, 0);
        repeat (12) step(0, 8'h99, 0);

        // invalid tens code
        step(1, 8'hA9, 0);
        repeat (16) step(0, 8'hA9, 0);

        // blank for 10 cycles, then release
        repeat (10) step(0, 8'h42, 1);
        repeat (10) step(0, 8'h42, 0);

        // reset mid-slot, then reset coincident with a tick
        repeat (2) step(0, 8'h68, 0);
        step(1, 8'h68, 0);
        repeat (5) step(0, 8'h68, 0);
        while (cyc4 % 4 != 2) step(0, 8'h68, 0);
        step(1, 8'h57, 0);
        repeat (8) step(0, 8'h57, 0);

        // randomized traffic, including invalid codes, blanking and resets
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 49) == 0), 8'($urandom), ($urandom_range(0, 7) == 0));
        end

        guard = 0;
        while (sb.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
